ad9958_spi_master: RTL and testbench
====================================

AD9958_SPI_MASTER -- requirements
Module: ad9958_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in clock cycles; legal range 1..255.
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 trigger  input  1  single-cycle transfer request from the DDS sequencer.
REQ-005 packs_to_send  input  5  transfer length in bytes; sampled with trigger.
REQ-006 data_input  input  64  payload, right-aligned; first byte sent is bits [8N-1:8N-8]; sampled with trigger.
REQ-007 busy  output  1  high while a transfer is in progress.
REQ-008 cs_n  output  1  AD9958 chip select, active low.
REQ-009 sclk  output  1  AD9958 serial clock.
REQ-010 sdio  output  4  4-bit serial data (SDIO_3..SDIO_0), MSB nibble first.
REQ-011 sdio_oe  output  1  data-pin output enable; equals ~cs_n.

Function
REQ-012 States SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO and GAP.
REQ-013 In IDLE, trigger=1 with packs_to_send != 0 SHALL latch N and data_input, set busy=1 on that same edge (visible the next cycle), and go to SETUP.
REQ-014 N SHALL be min(packs_to_send, 8); packs_to_send=0 SHALL be ignored (stay IDLE, busy stays 0).
REQ-015 trigger in any state other than IDLE SHALL be ignored; latched data SHALL be unaffected.
REQ-016 SETUP: cs_n=0, sclk=0, sdio=first nibble, held for CLK_DIV cycles, then go to SHIFT_HI.
REQ-017 SHIFT_HI: sclk=1 for CLK_DIV cycles with sdio stable; the AD9958 samples on the sclk rising edge.
REQ-018 SHIFT_LO: sclk=0 for CLK_DIV cycles.
REQ-019 sdio SHALL change only on the sclk falling edge, i.e. on entry to SHIFT_LO.
REQ-020 After SHIFT_LO, SHALL return to SHIFT_HI if nibbles remain, otherwise go to GAP.
REQ-021 The nibble counter SHALL count 2N nibbles; nibble k is data bits [8N-1-4k : 8N-4-4k].
REQ-022 GAP: cs_n=1, sclk=0, sdio=0, busy=1 for CLK_DIV cycles, then go to IDLE with busy=0.
REQ-023 busy high duration SHALL be exactly CLK_DIV*(4N+2) cycles.
REQ-024 A new trigger SHALL be accepted on the first cycle busy=0, so back-to-back transfers are separated by at least CLK_DIV cycles of cs_n high.
REQ-025 The half-period counter SHALL be 8 bits wide, reload to CLK_DIV-1 on every state change, and never wrap inside a phase.
REQ-026 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-027 While reset_n=0: state=IDLE, busy=0, cs_n=1, sclk=0, sdio=0, sdio_oe=0; latched data and counters cleared.
REQ-028 Reset asserted mid-transfer SHALL abort on that edge with the REQ-027 values; no partial completion.
REQ-029 A trigger coincident with reset_n=0 SHALL be discarded.

Verification
REQ-030 CLK_DIV=2, N=1, data=0xA5 -> cs_n low for 10 cycles, 2 sclk pulses, sdio=0xA then 0x5, busy high 12 cycles.
REQ-031 CLK_DIV=1, N=4, data=0x12345678 -> 8 sclk rising edges sample 1,2,3,4,5,6,7,8; busy high 18 cycles.
REQ-032 packs_to_send=0 with trigger -> busy, cs_n, sclk and sdio unchanged.
REQ-033 packs_to_send=12 with data=0x0123456789ABCDEF -> 8 bytes sent, 16 nibbles 0..F in order.
REQ-034 Second trigger during SHIFT_HI of a transfer -> ignored; the original payload completes unchanged.
REQ-035 reset_n=0 for one cycle during nibble 3 -> next cycle cs_n=1, busy=0, sclk=0; a following trigger starts a clean transfer.

Source files
------------

// File: rtl/ad9958_spi_master.sv
// Quad-SDIO serial master for the AD9958 DDS: shifts up to eight payload bytes
// out MSB-nibble first, framed by chip select, with a fixed inter-transfer gap.
module ad9958_spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        trigger,
    input  logic [4:0]  packs_to_send,
    input  logic [63:0] data_input,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic [3:0]  sdio,
    output logic        sdio_oe
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  half_cnt_r;
    logic [4:0]  nib_left_r;
    logic [63:0] shift_r;
    logic [3:0]  n_bytes_s;
    logic [63:0] aligned_s;

    // Clamp the byte count and left-align the payload so the next nibble is always [63:60].
    always_comb begin
        n_bytes_s = 4'd0;
        aligned_s = 64'd0;
        if (packs_to_send > 5'd8) begin
            n_bytes_s = 4'd8;
        end else begin
            n_bytes_s = packs_to_send[3:0];
        end
        aligned_s = data_input << (7'd64 - {n_bytes_s, 3'b000});
    end

    // Transfer sequencer; every output is set on the edge that enters its state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            half_cnt_r <= 8'd0;
            nib_left_r <= 5'd0;
            shift_r    <= 64'd0;
            busy       <= 1'b0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            sdio       <= 4'd0;
            sdio_oe    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (trigger && (packs_to_send != 5'd0)) begin
                        state_r    <= SETUP;
                        half_cnt_r <= DIV_RELOAD;
                        nib_left_r <= {n_bytes_s, 1'b0};
                        shift_r    <= aligned_s;
                        busy       <= 1'b1;
                        cs_n       <= 1'b0;
                        sdio_oe    <= 1'b1;
                        sclk       <= 1'b0;
                        sdio       <= aligned_s[63:60];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    if (half_cnt_r != 8'd0) begin
                        half_cnt_r <= half_cnt_r - 8'd1;
                    end else begin
                        state_r    <= SHIFT_HI;
                        half_cnt_r <= DIV_RELOAD;
                        sclk       <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (half_cnt_r != 8'd0) begin
                        half_cnt_r <= half_cnt_r - 8'd1;
                    end else begin
                        state_r    <= SHIFT_LO;
                        half_cnt_r <= DIV_RELOAD;
                        sclk       <= 1'b0;
                        nib_left_r <= nib_left_r - 5'd1;
                        shift_r    <= shift_r << 4;
                        // Data moves only on the falling edge; the last nibble is simply held.
                        if (nib_left_r > 5'd1) begin
                            sdio <= shift_r[59:56];
                        end else begin
                            sdio <= sdio;
                        end
                    end
                end
                SHIFT_LO: begin
                    if (half_cnt_r != 8'd0) begin
                        half_cnt_r <= half_cnt_r - 8'd1;
                    end else if (nib_left_r != 5'd0) begin
                        state_r    <= SHIFT_HI;
                        half_cnt_r <= DIV_RELOAD;
                        sclk       <= 1'b1;
                    end else begin
                        state_r    <= GAP;
                        half_cnt_r <= DIV_RELOAD;
                        cs_n       <= 1'b1;
                        sdio_oe    <= 1'b0;
                        sdio       <= 4'd0;
                    end
                end
                GAP: begin
                    if (half_cnt_r != 8'd0) begin
                        half_cnt_r <= half_cnt_r - 8'd1;
                    end else begin
                        state_r    <= IDLE;
                        half_cnt_r <= DIV_RELOAD;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    half_cnt_r <= 8'd0;
                    busy       <= 1'b0;
                    cs_n       <= 1'b1;
                    sclk       <= 1'b0;
                    sdio       <= 4'd0;
                    sdio_oe    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9958_spi_master.sv
// Self-checking bench: two masters (CLK_DIV 2 and 1) share stimulus and are
// compared against frame timing and nibble order derived from the byte count.
module tb_ad9958_spi_master;

    logic        clock;
    logic        reset_n;
    logic        trigger;
    logic [4:0]  packs_to_send;
    logic [63:0] data_input;

    logic       busy_a, cs_n_a, sclk_a, sdio_oe_a;
    logic [3:0] sdio_a;
    logic       busy_b, cs_n_b, sclk_b, sdio_oe_b;
    logic [3:0] sdio_b;

    logic [1:0] busy_w, cs_w, sclk_w, oe_w;
    logic [3:0] sdio_w [2];
    int         div_v [2];

    int checks;
    int failures;

    assign busy_w    = {busy_b, busy_a};
    assign cs_w      = {cs_n_b, cs_n_a};
    assign sclk_w    = {sclk_b, sclk_a};
    assign oe_w      = {sdio_oe_b, sdio_oe_a};
    assign sdio_w[0] = sdio_a;
    assign sdio_w[1] = sdio_b;

    ad9958_spi_master #(.CLK_DIV(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .trigger(trigger),
        .packs_to_send(packs_to_send), .data_input(data_input),
        .busy(busy_a), .cs_n(cs_n_a), .sclk(sclk_a), .sdio(sdio_a), .sdio_oe(sdio_oe_a)
    );

    ad9958_spi_master #(.CLK_DIV(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .trigger(trigger),
        .packs_to_send(packs_to_send), .data_input(data_input),
        .busy(busy_b), .cs_n(cs_n_b), .sclk(sclk_b), .sdio(sdio_b), .sdio_oe(sdio_oe_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_w[d], cs_w[d], sclk_w[d], sdio_w[d], oe_w[d]} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
                failures++;
                $display("FAIL %s dut%0d: busy/cs_n/sclk/sdio/oe = %b/%b/%b/%h/%b, required 0/1/0/0/0",
                         tag, d, busy_w[d], cs_w[d], sclk_w[d], sdio_w[d], oe_w[d]);
            end
        end
    endtask

    // Called right after a negedge; returns on the first negedge where both masters are idle.
    task automatic run_transfer(input logic [4:0] p, input logic [63:0] d, input int retrig_cyc, input string tag);
        int nb;
        logic [63:0] exp_vec;
        logic [63:0] got_vec [2];
        int busy_cnt [2], cs_cnt [2], rise_cnt [2], stab_bad [2], oe_bad [2];
        logic prev_sclk [2], prev_cs [2];
        logic [3:0] prev_sdio [2];
        bit done;
        nb = (p > 5'd8) ? 8 : int'(p);
        exp_vec = (nb == 8) ? d : (d & ((64'd1 << (8 * nb)) - 64'd1));
        for (int i = 0; i < 2; i++) begin
            got_vec[i] = 64'd0; busy_cnt[i] = 0; cs_cnt[i] = 0; rise_cnt[i] = 0;
            stab_bad[i] = 0; oe_bad[i] = 0; prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; prev_sdio[i] = 4'd0;
        end
        trigger = 1'b1; packs_to_send = p; data_input = d;
        @(negedge clock);
        trigger = 1'b0;
        packs_to_send = 5'($urandom_range(1, 31));
        data_input = {$urandom(), $urandom()};
        checks++;
        if (busy_w !== 2'b11) begin
            failures++;
            $display("FAIL %s accept: busy=%b, required 11 one cycle after trigger", tag, busy_w);
        end
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (busy_w[i]) busy_cnt[i]++;
                if (!cs_w[i]) cs_cnt[i]++;
                if (oe_w[i] !== ~cs_w[i]) oe_bad[i]++;
                if (cs_w[i] && (sclk_w[i] || sdio_w[i] != 4'd0)) stab_bad[i]++;
                if (sclk_w[i] && !prev_sclk[i]) begin
                    got_vec[i] = {got_vec[i][59:0], sdio_w[i]};
                    rise_cnt[i]++;
                end
                if (!cs_w[i] && !prev_cs[i] && sdio_w[i] != prev_sdio[i] && !(prev_sclk[i] && !sclk_w[i]))
                    stab_bad[i]++;
                prev_sclk[i] = sclk_w[i]; prev_cs[i] = cs_w[i]; prev_sdio[i] = sdio_w[i];
            end
            if (busy_w == 2'b00) begin
                done = 1'b1;
            end else begin
                if (cyc == retrig_cyc) begin
                    trigger = 1'b1;
                    packs_to_send = 5'($urandom_range(1, 31));
                    data_input = {$urandom(), $urandom()};
                end else begin
                    trigger = 1'b0;
                end
                @(negedge clock);
            end
        end
        trigger = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: busy=%b still set after 200 cycles, required 00", tag, busy_w);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_cnt[i] != div_v[i] * (4 * nb + 2)) begin
                failures++;
                $display("FAIL %s busy_len dut%0d: %0d cycles, required %0d", tag, i, busy_cnt[i], div_v[i] * (4 * nb + 2));
            end
            checks++;
            if (cs_cnt[i] != div_v[i] * (4 * nb + 1)) begin
                failures++;
                $display("FAIL %s cs_len dut%0d: %0d cycles, required %0d", tag, i, cs_cnt[i], div_v[i] * (4 * nb + 1));
            end
            checks++;
            if (rise_cnt[i] != 2 * nb) begin
                failures++;
                $display("FAIL %s sclk_rises dut%0d: %0d, required %0d", tag, i, rise_cnt[i], 2 * nb);
            end
            checks++;
            if (got_vec[i] !== exp_vec) begin
                failures++;
                $display("FAIL %s nibbles dut%0d: %h, required %h", tag, i, got_vec[i], exp_vec);
            end
            checks++;
            if (stab_bad[i] != 0 || oe_bad[i] != 0) begin
                failures++;
                $display("FAIL %s pin_rules dut%0d: %0d sdio/idle violations, %0d oe violations, required 0/0",
                         tag, i, stab_bad[i], oe_bad[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trigger = 1'b1; packs_to_send = 5'd3; data_input = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(negedge clock);
        check_idle("reset_hold");
        reset_n = 1'b1; trigger = 1'b0;
        @(negedge clock);
        check_idle("reset_release");
    endtask

    task automatic test_directed();
        run_transfer(5'd1, 64'h0000_0000_0000_00A5, -1, "a5");
        run_transfer(5'd4, 64'h0000_0000_1234_5678, -1, "x12345678");
        run_transfer(5'd12, 64'h0123_4567_89AB_CDEF, -1, "overlong");
    endtask

    task automatic test_zero_packs();
        trigger = 1'b1; packs_to_send = 5'd0; data_input = 64'h55;
        @(negedge clock);
        trigger = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("zero_packs");
            @(negedge clock);
        end
    endtask

    task automatic test_retrigger();
        run_transfer(5'd2, {$urandom(), $urandom()}, 6, "retrig_hi");
        run_transfer(5'd3, {$urandom(), $urandom()}, 3, "retrig_early");
    endtask

    task automatic test_back_to_back();
        run_transfer(5'd1, {$urandom(), $urandom()}, -1, "b2b_first");
        run_transfer(5'd2, {$urandom(), $urandom()}, -1, "b2b_second");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++)
            run_transfer(5'($urandom_range(1, 16)), {$urandom(), $urandom()}, -1, "random");
    endtask

    task automatic test_reset_abort();
        int rises;
        logic prev;
        bit hit;
        rises = 0; prev = 1'b0; hit = 1'b0;
        trigger = 1'b1; packs_to_send = 5'd4; data_input = {$urandom(), $urandom()};
        @(negedge clock);
        trigger = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            if (rises == 3 && sclk_a) hit = 1'b1;
            else @(negedge clock);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL abort_reach: saw %0d sclk rises, required 3", rises);
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_idle("abort");
        reset_n = 1'b0; trigger = 1'b1; packs_to_send = 5'd3;
        @(negedge clock);
        reset_n = 1'b1; trigger = 1'b0;
        @(negedge clock);
        check_idle("trigger_in_reset");
        run_transfer(5'd3, {$urandom(), $urandom()}, -1, "after_abort");
    endtask

    initial begin
        checks = 0; failures = 0;
        div_v[0] = 2; div_v[1] = 1;
        reset_n = 1'b0; trigger = 1'b0; packs_to_send = 5'd0; data_input = 64'd0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_zero_packs();
        test_retrigger();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
